counter_io_bank: RTL

//  Multi-channel generalisation of the single free-running 8-bit counter that drives SB_IO pins.
//  - CHANNELS independent WIDTH-bit counters; each has enable, synchronous load, direction and a prescaler.
//  - Each channel has a wrap or saturate mode and a terminal-count pulse.
//  - Count values leave the block on pin_out, optionally through iCE40 SB_IO output registers.
//  - Sits between control logic and the FPGA pads: LED/strobe/PWM-base generation.

---
 rtl/counter_io_bank.sv | 119 +++++++++++
 1 files changed

// File: rtl/counter_io_bank.sv
// ============================================================================
//  Module  : counter_io_bank
//  Purpose : Bank of independent prescaled up/down counters with wrap or
//            saturate mode, terminal-count pulses and a pad-side copy of each
//            count. The optional iCE40 SB_IO output stage is enabled by
//            defining COUNTER_IO_BANK_SBIO_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_io_bank #(
    parameter int          CHANNELS = 4,
    parameter int          WIDTH    = 8,
    parameter int unsigned STEP     = 1,
    parameter int          DIV      = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS-1:0]       up,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS*WIDTH-1:0] pin_out
);

    localparam logic [WIDTH-1:0] c_step = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_max  = '1;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic             r_tc;
        logic             w_tick;
        logic [WIDTH:0]   w_sum;
        logic [WIDTH:0]   w_diff;
        logic [WIDTH-1:0] w_next;
        logic             w_hit;

        if (DIV > 1) begin : g_pre
            localparam int PW = $clog2(DIV);
            logic [PW-1:0] r_pre;

            assign w_tick = (r_pre == PW'(DIV - 1));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_pre <= '0;
                end else if (load[gi]) begin
                    r_pre <= '0;
                end else if (en[gi]) begin
                    r_pre <= w_tick ? '0 : r_pre + PW'(1);
                end
            end
        end else begin : g_nopre
            assign w_tick = 1'b1;
        end

        // The extra MSB of sum/diff is the carry or borrow out of the counter.
        always_comb begin
            w_sum  = {1'b0, r_cnt} + {1'b0, c_step};
            w_diff = {1'b0, r_cnt} - {1'b0, c_step};
            w_next = r_cnt;
            w_hit  = 1'b0;
            if (SATURATE) begin
                if (up[gi]) begin
                    w_next = w_sum[WIDTH] ? c_max : w_sum[WIDTH-1:0];
                    w_hit  = (w_next == c_max) && (r_cnt != c_max);
                end else begin
                    w_next = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
                    w_hit  = (w_next == '0) && (r_cnt != '0);
                end
            end else begin
                w_next = up[gi] ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
                w_hit  = up[gi] ? w_sum[WIDTH] : w_diff[WIDTH];
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
                r_tc  <= 1'b0;
            end else if (load[gi]) begin
                r_cnt <= load_value[gi*WIDTH +: WIDTH];
                r_tc  <= 1'b0;
            end else if (en[gi] && w_tick) begin
                r_cnt <= w_next;
                r_tc  <= w_hit;
            end else begin
                r_tc  <= 1'b0;
            end
        end

        assign count[gi*WIDTH +: WIDTH] = r_cnt;
        assign tc[gi]                   = r_tc;
    end

`ifdef COUNTER_IO_BANK_SBIO_EN
    // Count is forced to zero while reset is held, so the pad register follows it.
    for (genvar gb = 0; gb < CHANNELS*WIDTH; gb++) begin : g_pin
        SB_IO #(
            .PIN_TYPE (6'b010100),
            .PULLUP   (1'b0)
        ) u_sbio (
            .PACKAGE_PIN   (pin_out[gb]),
            .OUTPUT_CLK    (clock),
            .CLOCK_ENABLE  (1'b1),
            .OUTPUT_ENABLE (1'b1),
            .D_OUT_0       (count[gb])
        );
    end
`else
    assign pin_out = count;
`endif

endmodule

`default_nettype wire
